// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver. Commands are shadowed at period boundaries; pins lag cnt by one cycle; no backpressure.
// Optional SOFT_START_EN ramps drive duty by +1 per period (decreases apply immediately).

module motor_pwm_channel #(
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk_3125KHz,
  input  logic       reset,
  input  logic       boundary,
  input  logic [4:0] cnt,
  input  logic [1:0] cmd_dir,
  input  logic [4:0] cmd_duty,
  output logic       in1,
  output logic       in2,
  output logic       busy
);

  typedef enum logic {RUN, DEAD} state_t;

  localparam logic [3:0] DEAD_LAST = 4'(DEAD_PERIODS - 1);

  state_t     state, state_n;
  logic [3:0] dead_cnt, dead_cnt_n;
  logic [1:0] app_dir, app_dir_n;
  logic [4:0] app_duty, app_duty_n;
  logic [4:0] next_duty;
  logic       pwm;

`ifdef SOFT_START_EN
  // Ramp only while continuing in the same drive direction; any fresh entry restarts at 0.
  always_comb begin
    next_duty = cmd_duty;
    if (cmd_dir[1] ^ cmd_dir[0]) begin
      if (state == RUN && app_dir == cmd_dir) begin
        if (cmd_duty > app_duty)
          next_duty = app_duty + 5'd1;
      end else begin
        next_duty = 5'd0;
      end
    end
  end
`else
  assign next_duty = cmd_duty;
`endif

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      dead_cnt <= 4'd0;
      app_dir  <= 2'b00;
      app_duty <= 5'd0;
    end else begin
      state    <= state_n;
      dead_cnt <= dead_cnt_n;
      app_dir  <= app_dir_n;
      app_duty <= app_duty_n;
    end
  end

  always_comb begin
    state_n    = state;
    dead_cnt_n = dead_cnt;
    app_dir_n  = app_dir;
    app_duty_n = app_duty;
    if (boundary) begin
      case (state)
        RUN: begin
          // A forward/reverse swap must pass through coast first.
          if ((cmd_dir[1] ^ cmd_dir[0]) && (app_dir[1] ^ app_dir[0]) && (cmd_dir != app_dir)) begin
            state_n    = DEAD;
            app_dir_n  = 2'b00;
            app_duty_n = 5'd0;
            dead_cnt_n = DEAD_LAST;
          end else begin
            app_dir_n  = cmd_dir;
            app_duty_n = next_duty;
          end
        end
        DEAD: begin
          if (dead_cnt == 4'd0) begin
            state_n    = RUN;
            app_dir_n  = cmd_dir;
            app_duty_n = next_duty;
          end else begin
            dead_cnt_n = dead_cnt - 4'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign pwm  = (cnt < app_duty);
  assign busy = (state == DEAD);

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      in1 <= 1'b0;
      in2 <= 1'b0;
    end else begin
      case (app_dir)
        2'b10:   begin in1 <= pwm;  in2 <= 1'b0; end
        2'b01:   begin in1 <= 1'b0; in2 <= pwm;  end
        2'b11:   begin in1 <= 1'b1; in2 <= 1'b1; end
        default: begin in1 <= 1'b0; in2 <= 1'b0; end
      endcase
    end
  end

endmodule

module motor_pwm_driver #(
  parameter int PRESCALE     = 4,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       clk_3125KHz,
  input  logic       reset,
  input  logic       m1_a,
  input  logic       m1_b,
  input  logic       m2_a,
  input  logic       m2_b,
  input  logic [4:0] dc1,
  input  logic [4:0] dc2,
  output logic       motor1_in1,
  output logic       motor1_in2,
  output logic       motor2_in1,
  output logic       motor2_in2,
  output logic       period_start,
  output logic [1:0] dir_busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic [4:0]    cnt;
  logic          started;
  logic          tick;
  logic          boundary;

  assign tick     = (presc == PW'(PRESCALE - 1));
  assign boundary = tick && (cnt == 5'd31);

  always_ff @(posedge clk_3125KHz or posedge reset) begin
    if (reset) begin
      presc   <= '0;
      cnt     <= 5'd0;
      started <= 1'b0;
    end else begin
      started <= 1'b1;
      if (tick) begin
        presc <= '0;
        cnt   <= cnt + 5'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Suppressed on the very first cycle after reset, where presc/cnt sit at 0 before counting.
  assign period_start = started && (presc == '0) && (cnt == 5'd0);

  motor_pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_m1 (
    .clk_3125KHz (clk_3125KHz),
    .reset       (reset),
    .boundary    (boundary),
    .cnt         (cnt),
    .cmd_dir     ({m1_a, m1_b}),
    .cmd_duty    (dc1),
    .in1         (motor1_in1),
    .in2         (motor1_in2),
    .busy        (dir_busy[0])
  );

  motor_pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_m2 (
    .clk_3125KHz (clk_3125KHz),
    .reset       (reset),
    .boundary    (boundary),
    .cnt         (cnt),
    .cmd_dir     ({m2_a, m2_b}),
    .cmd_duty    (dc2),
    .in1         (motor2_in1),
    .in2         (motor2_in2),
    .busy        (dir_busy[1])
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver at PRESCALE=4, DEAD_PERIODS=2 (128-cycle period).
module tb_motor_pwm_driver;

  logic       clk_3125KHz = 1'b0;
  logic       reset = 1'b1;
  logic       m1_a = 0, m1_b = 0, m2_a = 0, m2_b = 0;
  logic [4:0] dc1 = 0, dc2 = 0;
  logic       motor1_in1, motor1_in2, motor2_in1, motor2_in2, period_start;
  logic [1:0] dir_busy;

  int checks = 0;
  int errors = 0;

  motor_pwm_driver #(.PRESCALE(4), .DEAD_PERIODS(2)) dut (
    .clk_3125KHz  (clk_3125KHz),
    .reset        (reset),
    .m1_a         (m1_a),
    .m1_b         (m1_b),
    .m2_a         (m2_a),
    .m2_b         (m2_b),
    .dc1          (dc1),
    .dc2          (dc2),
    .motor1_in1   (motor1_in1),
    .motor1_in2   (motor1_in2),
    .motor2_in1   (motor2_in1),
    .motor2_in2   (motor2_in2),
    .period_start (period_start),
    .dir_busy     (dir_busy)
  );

  always #5 clk_3125KHz = ~clk_3125KHz;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] d1; logic [4:0] c1; logic [1:0] d2; logic [4:0] c2;
    int e11; int e12; int e21; int e22; logic [1:0] busy;
  } vec_t;

  typedef struct {int e11; int e12; int e21; int e22; logic [1:0] busy;} exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d1, input logic [4:0] c1, input logic [1:0] d2, input logic [4:0] c2);
    {m1_a, m1_b} = d1; dc1 = c1;
    {m2_a, m2_b} = d2; dc2 = c2;
  endtask

  // Counts high samples over n negedges; ends on the last sampled negedge.
  task automatic measure(input int n, output int c11, output int c12, output int c21, output int c22,
                         output int ps_cnt, output int ps_last, output int busy_cnt);
    c11 = 0; c12 = 0; c21 = 0; c22 = 0; ps_cnt = 0; ps_last = 0; busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk_3125KHz);
      c11 += int'(motor1_in1); c12 += int'(motor1_in2);
      c21 += int'(motor2_in1); c22 += int'(motor2_in2);
      ps_cnt += int'(period_start);
      busy_cnt += int'(dir_busy[0]);
      ps_last = int'(period_start);
    end
  endtask

  initial begin
    vec_t vecs[10];
    exp_t e;
    int c11, c12, c21, c22, psc, psl, bc;
    logic [1:0] busy_s;

    vecs = '{
      '{2'b10, 5'd16, 2'b01, 5'd0,  64,   0,  0,   0, 2'b00},
      '{2'b10, 5'd16, 2'b01, 5'd31, 64,   0,  0, 124, 2'b00},
      '{2'b10, 5'd20, 2'b01, 5'd31, 80,   0,  0, 124, 2'b00},
      '{2'b01, 5'd20, 2'b01, 5'd31,  0,   0,  0, 124, 2'b01},
      '{2'b01, 5'd20, 2'b01, 5'd31,  0,  80,  0, 124, 2'b00},
      '{2'b11, 5'd5,  2'b10, 5'd8, 128, 128,  0,   0, 2'b10},
      '{2'b10, 5'd7,  2'b10, 5'd8,  28,   0, 32,   0, 2'b00},
      '{2'b00, 5'd7,  2'b10, 5'd8,   0,   0, 32,   0, 2'b00},
      '{2'b01, 5'd31, 2'b00, 5'd9,   0, 124,  0,   0, 2'b00},
      '{2'b00, 5'd0,  2'b00, 5'd0,   0,   0,  0,   0, 2'b00}
    };

    drive(2'b00, 5'd0, 2'b00, 5'd0);
    repeat (3) @(negedge clk_3125KHz);
    check("reset_pins", int'({motor1_in1, motor1_in2, motor2_in1, motor2_in2}), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_busy", int'(dir_busy), 0);
    reset = 1'b0;
    #1 check("first_cycle_no_period_start", int'(period_start), 0);

`ifndef SOFT_START_EN
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("first_period_start_at_128", psl, 1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].d1, vecs[i].c1, vecs[i].d2, vecs[i].c2);
      sb.push_back('{vecs[i].e11, vecs[i].e12, vecs[i].e21, vecs[i].e22, vecs[i].busy});
      measure(128, c11, c12, c21, c22, psc, psl, bc);
      busy_s = dir_busy;
      measure(128, c11, c12, c21, c22, psc, psl, bc);
      e = sb.pop_front();
      check($sformatf("v%0d_m1_in1", i), c11, e.e11);
      check($sformatf("v%0d_m1_in2", i), c12, e.e12);
      check($sformatf("v%0d_m2_in1", i), c21, e.e21);
      check($sformatf("v%0d_m2_in2", i), c22, e.e22);
      check($sformatf("v%0d_dir_busy", i), int'(busy_s), int'(e.busy));
      check($sformatf("v%0d_period_start_spacing", i), psc * 2 + psl, 3);
    end

    // Reversal 10->01 at duty 20: old period, two coast periods, then two reversed periods.
    drive(2'b10, 5'd20, 2'b00, 5'd0);
    measure(256, c11, c12, c21, c22, psc, psl, bc);
    drive(2'b01, 5'd20, 2'b00, 5'd0);
    measure(640, c11, c12, c21, c22, psc, psl, bc);
    check("rev_old_in1", c11, 80);
    check("rev_new_in2", c12, 160);
    check("rev_busy_cycles", bc, 256);

    // Duty change mid-period must not reach the pins before the next period.
    drive(2'b00, 5'd0, 2'b01, 5'd31);
    measure(256, c11, c12, c21, c22, psc, psl, bc);
    measure(64, c11, c12, c21, c22, psc, psl, bc);
    check("mid_first_half_in2", c22, 64);
    drive(2'b00, 5'd0, 2'b01, 5'd0);
    measure(64, c11, c12, c21, c22, psc, psl, bc);
    check("mid_second_half_in2", c22, 60);
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("mid_next_period_in2", c22, 0);

    // Asynchronous reset while in1 is high.
    drive(2'b10, 5'd16, 2'b00, 5'd0);
    measure(256, c11, c12, c21, c22, psc, psl, bc);
    measure(10, c11, c12, c21, c22, psc, psl, bc);
    check("pre_reset_in1_high", int'(motor1_in1), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pins", int'({motor1_in1, motor1_in2, motor2_in1, motor2_in2}), 0);
    check("async_reset_period_start", int'(period_start), 0);
    @(negedge clk_3125KHz);
    reset = 1'b0;
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("post_reset_coast_in1", c11, 0);
    check("post_reset_period_start", psc * 2 + psl, 3);
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("post_reset_first_period_in1", c11, 64);
`else
    drive(2'b10, 5'd5, 2'b00, 5'd0);
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    for (int i = 0; i < 6; i++) sb.push_back('{4 * i, 0, 0, 0, 2'b00});
    for (int i = 0; i < 6; i++) begin
      measure(128, c11, c12, c21, c22, psc, psl, bc);
      e = sb.pop_front();
      check($sformatf("ramp%0d_in1", i), c11, e.e11);
      check($sformatf("ramp%0d_in2", i), c12, e.e12);
    end
    drive(2'b10, 5'd2, 2'b00, 5'd0);
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("ramp_hold_in1", c11, 20);
    measure(128, c11, c12, c21, c22, psc, psl, bc);
    check("ramp_drop_in1", c11, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_pwm_driver.md
Name: motor_pwm_driver

Overview:
- Consumes the line-follower motor command interface (per-motor direction pair plus 5-bit duty) and generates the four H-bridge drive pins for the left and right DC motors.
- Shadows commands at PWM period boundaries so the drive pins never glitch mid-period.
- Inserts coast dead-time on forward/reverse reversals to protect the H-bridge.
- Sits between the line-following controller and the motor driver IC pins.

Parameters:
- PRESCALE, 4: clk_3125KHz cycles per PWM step (min 1); period = 32*PRESCALE cycles, about 24.4 kHz at default.
- DEAD_PERIODS, 2: whole PWM periods of forced coast on a direction reversal (min 1, max 15).

Ports:
- clk_3125KHz  in  1  system clock, 3.125 MHz
- reset  in  1  asynchronous, active-high reset
- m1_a  in  1  motor 1 (left) direction bit a
- m1_b  in  1  motor 1 direction bit b
- m2_a  in  1  motor 2 (right) direction bit a
- m2_b  in  1  motor 2 direction bit b
- dc1  in  5  motor 1 duty, 0..31 (x/32)
- dc2  in  5  motor 2 duty, 0..31
- motor1_in1  out  1  H-bridge pin, motor 1 side A
- motor1_in2  out  1  H-bridge pin, motor 1 side B
- motor2_in1  out  1  H-bridge pin, motor 2 side A
- motor2_in2  out  1  H-bridge pin, motor 2 side B
- period_start  out  1  one-cycle pulse on the first cycle of each PWM period
- dir_busy  out  2  bit0/bit1 high while motor 1/2 is in dead-time

Behaviour:
- Reset (async): all outputs 0, prescaler 0, step counter 0, shadow duty/dir 0, both motors in RUN with applied dir 00. Asserting reset mid-period forces pins low immediately.
- Timing:
  - presc counts 0..PRESCALE-1; a step tick occurs at presc==PRESCALE-1.
  - 5-bit cnt increments on each tick and wraps 31->0.
  - period_start=1 exactly when presc==0 && cnt==0, excluding the first cycle after reset release.
- Boundary:
  - The boundary is the cycle with presc==PRESCALE-1 && cnt==31.
  - On it, {mX_a,mX_b} and dcX are sampled into target registers. The applied values change so that cnt==0 of the next period uses them.
  - Input changes at any other time are ignored until the next boundary. Latency from command to pins is at most 32*PRESCALE+1 cycles.
- PWM: pwm_X = (cnt < applied_duty). Duty 0 gives constant low; duty 31 gives high for 31 of 32 steps.
- Pin map per applied dir:
  - 10: in1=pwm, in2=0.
  - 01: in1=0, in2=pwm.
  - 11: brake, in1=in2=1 constant, duty ignored.
  - 00: coast, both 0.
- Pins are registered, one cycle after cnt/presc.
- Per-motor FSM, states RUN and DEAD:
  - RUN -> DEAD at a boundary when the sampled dir is 10/01 and differs from an applied dir of 10/01 (a reversal). On entry, applied dir=00, dead_cnt=DEAD_PERIODS-1, dir_busy=1.
  - All other dir changes (to/from 00 or 11) apply directly at the boundary.
  - DEAD: pins held 00. Each boundary re-samples target (the latest command wins) and decrements dead_cnt. At the boundary where dead_cnt==0, target dir/duty apply and the FSM returns to RUN with dir_busy=0.
  - If the latest target in DEAD is 00 or 11, it applies and exits at that same dead_cnt==0 boundary; no early exit.
- The two motors are fully independent and share only presc/cnt.

Optional Feature:
- Macro SOFT_START_EN.
- When defined: in RUN with a drive dir (10/01), applied_duty moves toward target_duty by at most +1 per boundary while increasing. Decreases apply immediately. Entry from 00, 11 or DEAD starts applied_duty at 0 and ramps.
- When undefined: applied_duty=target_duty at each boundary.

Test Plan (PRESCALE=4, DEAD_PERIODS=2, period 128 cycles):
- m1=10, dc1=16, held: after first boundary, motor1_in1 high 64 consecutive cycles of every 128, motor1_in2=0; period_start every 128 cycles.
- m2=01, dc2=0 then dc2=31: in2 constant 0, then high 124 of 128 cycles starting the period after the boundary; dc2 changed mid-period gives no change until the next cnt==0.
- m1 10->01 at dc1=20: dir_busy[0]=1 and both pins 0 for exactly 2 periods (256 cycles), then in2 PWM 80/128 cycles; 10->00 instead coasts at the next boundary with no busy.
- m1=11: both pins constant 1 regardless of dc1; 11->10 takes effect at the next boundary without dead-time.
- Reset asserted mid-period with in1 high: all pins and period_start drop to 0 on the same cycle without a clock; after release, counters restart from 0 and dir 00 is held until the first boundary.
- (SOFT_START_EN) 00->10 with dc1=5: applied duty 0,1,2,3,4,5 over successive periods; then dc1=2 takes effect at the next boundary.
